// File: rtl/fence_i_sequencer.sv
// FENCE.I controller: stalls the core, drains the D-cache, writes back every dirty line,
// flushes the I-cache, then returns a one-cycle completion pulse to the core.
module fence_i_sequencer #(
    parameter int SET_NUM = 64,
    parameter int WAY_NUM = 2,
    parameter int LINE_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fence_req,
    output logic              fence_done,
    output logic              core_stall,
    input  logic              dc_busy,
    output logic              scan_valid,
    output logic [LINE_W-1:0] scan_line,
    input  logic              scan_ready,
    input  logic              scan_rsp_valid,
    input  logic              scan_rsp_dirty,
    output logic              wb_valid,
    input  logic              wb_done,
    output logic              icache_flush,
    input  logic              icache_flush_done,
    output logic [LINE_W:0]   wb_count
);

    localparam int                LINE_NUM  = SET_NUM * WAY_NUM;
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINE_NUM - 1);
    localparam logic [LINE_W:0]   WB_MAX    = (LINE_W + 1)'(LINE_NUM);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DRAIN,
        S_SCAN,
        S_WAIT_RSP,
        S_WB,
        S_NEXT,
        S_IFLUSH,
        S_IWAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [LINE_W-1:0] line_cnt;

    // The line id doubles as the scan/write-back address, held stable across both handshakes.
    assign scan_line  = line_cnt;
    assign core_stall = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            line_cnt     <= '0;
            wb_count     <= '0;
            scan_valid   <= 1'b0;
            wb_valid     <= 1'b0;
            icache_flush <= 1'b0;
            fence_done   <= 1'b0;
        end else begin
            icache_flush <= 1'b0;
            fence_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fence_req) begin
                        state    <= S_DRAIN;
                        line_cnt <= '0;
                        wb_count <= '0;
                    end
                end
                S_DRAIN: begin
                    if (!dc_busy) begin
                        state      <= S_SCAN;
                        scan_valid <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (scan_ready) begin
                        state      <= S_WAIT_RSP;
                        scan_valid <= 1'b0;
                    end
                end
                S_WAIT_RSP: begin
                    if (scan_rsp_valid) begin
                        if (scan_rsp_dirty) begin
                            state    <= S_WB;
                            wb_valid <= 1'b1;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_WB: begin
                    if (wb_done) begin
                        state    <= S_NEXT;
                        wb_valid <= 1'b0;
                        if (wb_count != WB_MAX) begin
                            wb_count <= wb_count + 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    // Stop on the last line id rather than relying on the counter wrapping.
                    if (line_cnt == LAST_LINE) begin
                        state        <= S_IFLUSH;
                        icache_flush <= 1'b1;
                    end else begin
                        state      <= S_SCAN;
                        line_cnt   <= line_cnt + 1'b1;
                        scan_valid <= 1'b1;
                    end
                end
                S_IFLUSH: begin
                    state <= S_IWAIT;
                end
                S_IWAIT: begin
                    if (icache_flush_done) begin
                        state      <= S_DONE;
                        fence_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Core must drop its request before another fence can start.
                    if (!fence_req) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fence_i_sequencer.sv
// Randomized bench for fence_i_sequencer: responders with per-line delays, latency and
// ordering predicted from the sequencing rules by plain arithmetic over a per-line table.
module tb_fence_i_sequencer;

    localparam int SET_NUM = 64;
    localparam int WAY_NUM = 2;
    localparam int LINE_W  = 7;
    localparam int N       = SET_NUM * WAY_NUM;

    logic              clk = 1'b0;
    logic              rst;
    logic              fence_req;
    logic              fence_done;
    logic              core_stall;
    logic              dc_busy;
    logic              scan_valid;
    logic [LINE_W-1:0] scan_line;
    logic              scan_ready;
    logic              scan_rsp_valid;
    logic              scan_rsp_dirty;
    logic              wb_valid;
    logic              wb_done;
    logic              icache_flush;
    logic              icache_flush_done;
    logic [LINE_W:0]   wb_count;

    fence_i_sequencer #(
        .SET_NUM(SET_NUM),
        .WAY_NUM(WAY_NUM),
        .LINE_W (LINE_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fence_req        (fence_req),
        .fence_done       (fence_done),
        .core_stall       (core_stall),
        .dc_busy          (dc_busy),
        .scan_valid       (scan_valid),
        .scan_line        (scan_line),
        .scan_ready       (scan_ready),
        .scan_rsp_valid   (scan_rsp_valid),
        .scan_rsp_dirty   (scan_rsp_dirty),
        .wb_valid         (wb_valid),
        .wb_done          (wb_done),
        .icache_flush     (icache_flush),
        .icache_flush_done(icache_flush_done),
        .wb_count         (wb_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-line responder behaviour for the next fence.
    int rdly [N];
    int sdly [N];
    int wdly [N];
    bit dirty[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            rdly[i]  = 0;
            sdly[i]  = 0;
            wdly[i]  = 0;
            dirty[i] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        fence_req         = 1'b0;
        dc_busy           = 1'b0;
        scan_ready        = 1'b0;
        scan_rsp_valid    = 1'b0;
        scan_rsp_dirty    = 1'b0;
        wb_done           = 1'b0;
        icache_flush_done = 1'b0;
    endtask

    // Cycle (counting the request-sampling edge as 1) at which fence_done is expected high.
    function automatic int exp_done(input int busy, input int fdly);
        int total;
        total = 3 * N + 4 + ((busy > 1) ? busy - 1 : 0) + fdly;
        for (int i = 0; i < N; i++) begin
            total += rdly[i] + sdly[i];
            if (dirty[i]) total += 1 + wdly[i];
        end
        return total;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_scan_valid"}, 32'(scan_valid), 0);
        check({tag, "_scan_line"}, 32'(scan_line), 0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 0);
        check({tag, "_icache_flush"}, 32'(icache_flush), 0);
        check({tag, "_fence_done"}, 32'(fence_done), 0);
        check({tag, "_core_stall"}, 32'(core_stall), 0);
        check({tag, "_wb_count"}, 32'(wb_count), 0);
    endtask

    task automatic run_fence(input string name, input int busy, input bit spur,
                             input int hold, input int abort_line, input int fdly);
        int cyc = 0, done_cyc = -1, first_scan = -1, flush_pulses = 0;
        int scanq[$], wbq[$], expwb[$];
        int scan_cyc = 0, wb_cyc = 0, rsp_cnt = 0, rsp_line = 0, iw_cnt = 0;
        int stab_err = 0, stall_err = 0, seq_err = 0, hold_err = 0;
        bit rsp_pend = 0, iw_pend = 0, prev_sv = 0, prev_wv = 0, scanning = 0;
        logic [LINE_W-1:0] prev_line = '0;

        fence_req = 1'b1;
        dc_busy   = (busy > 0);
        while (done_cyc < 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (core_stall !== 1'b1) stall_err++;
            if (scan_valid) begin
                if (first_scan < 0) first_scan = cyc;
                scanning = 1;
                if (prev_sv && scan_line != prev_line) stab_err++;
            end
            if (wb_valid) begin
                if (prev_wv && scan_line != prev_line) stab_err++;
                if (!prev_wv) wbq.push_back(int'(scan_line));
            end
            if (icache_flush) flush_pulses++;
            if (fence_done) done_cyc = cyc;
            if (abort_line >= 0 && wb_valid && int'(scan_line) == abort_line) begin
                idle_inputs();
                rst = 1'b1;
                @(negedge clk);
                check_all_zero({name, "_after_rst"});
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            prev_sv   = scan_valid;
            prev_wv   = wb_valid;
            prev_line = scan_line;

            // Responder inputs for this cycle; spurious values only where they must be ignored.
            dc_busy           = (scanning && spur) ? (($urandom & 1) == 1) : (cyc < busy);
            scan_ready        = spur ? (($urandom & 1) == 1) : 1'b0;
            scan_rsp_valid    = spur ? (($urandom & 1) == 1) : 1'b0;
            scan_rsp_dirty    = (($urandom & 1) == 1);
            wb_done           = spur ? (($urandom & 1) == 1) : 1'b0;
            icache_flush_done = spur ? (($urandom & 1) == 1) : 1'b0;
            if (rsp_pend) begin
                scan_rsp_valid = (rsp_cnt == 0);
                if (rsp_cnt == 0) begin
                    scan_rsp_dirty = dirty[rsp_line];
                    rsp_pend = 0;
                end else begin
                    rsp_cnt--;
                end
            end
            if (scan_valid) begin
                scan_ready = (scan_cyc == rdly[scan_line]);
                if (scan_ready) begin
                    scanq.push_back(int'(scan_line));
                    rsp_pend = 1;
                    rsp_cnt  = sdly[scan_line];
                    rsp_line = int'(scan_line);
                    scan_cyc = 0;
                end else begin
                    scan_cyc++;
                end
            end
            if (wb_valid) begin
                wb_done = (wb_cyc == wdly[scan_line]);
                wb_cyc  = wb_done ? 0 : wb_cyc + 1;
            end
            if (iw_pend) begin
                icache_flush_done = (iw_cnt == 0);
                if (iw_cnt == 0) iw_pend = 0;
                else iw_cnt--;
            end
            if (icache_flush) begin
                iw_pend = 1;
                iw_cnt  = fdly;
            end
        end

        if (done_cyc < 0) begin
            check({name, "_timeout"}, 0, 1);
            idle_inputs();
            return;
        end

        for (int i = 0; i < N; i++) if (dirty[i]) expwb.push_back(i);
        check({name, "_done_cycle"}, done_cyc, exp_done(busy, fdly));
        check({name, "_first_scan"}, first_scan, 2 + ((busy > 1) ? busy - 1 : 0));
        check({name, "_scan_count"}, scanq.size(), N);
        for (int i = 0; i < scanq.size(); i++) if (scanq[i] != i) seq_err++;
        check({name, "_scan_order_errs"}, seq_err, 0);
        check({name, "_wb_windows"}, wbq.size(), expwb.size());
        for (int i = 0; i < wbq.size() && i < expwb.size(); i++)
            check({name, "_wb_line"}, wbq[i], expwb[i]);
        check({name, "_flush_pulses"}, flush_pulses, 1);
        check({name, "_line_stability_errs"}, stab_err, 0);
        check({name, "_stall_low_errs"}, stall_err, 0);
        check({name, "_wb_count"}, 32'(wb_count), (expwb.size() > N) ? N : expwb.size());

        idle_inputs();
        fence_req = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (fence_done || !core_stall || scan_valid || wb_valid || icache_flush) hold_err++;
        end
        check({name, "_hold_errs"}, hold_err, 0);
        fence_req = 1'b0;
        @(negedge clk);
        check({name, "_stall_after_drop"}, 32'(core_stall), 0);
        check({name, "_wb_count_held"}, 32'(wb_count), expwb.size());
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        clear_cfg();
        run_fence("clean", 0, 0, 0, -1, 0);

        clear_cfg();
        dirty[5]  = 1'b1;
        dirty[70] = 1'b1;
        wdly[5]   = 10;
        wdly[70]  = 10;
        run_fence("dirty2", 0, 0, 0, -1, 0);

        clear_cfg();
        run_fence("busy20", 20, 0, 0, -1, 0);

        clear_cfg();
        rdly[0] = 4;
        run_fence("ready_wait", 0, 1, 0, -1, 0);

        clear_cfg();
        dirty[33] = 1'b1;
        wdly[33]  = 20;
        run_fence("reset_abort", 0, 0, 0, 33, 0);

        clear_cfg();
        run_fence("restart_hold", 0, 0, 5, -1, 0);

        clear_cfg();
        run_fence("rerequest", 0, 0, 0, -1, 0);

        clear_cfg();
        for (int i = 0; i < N; i++) dirty[i] = 1'b1;
        run_fence("all_dirty", 0, 0, 1, -1, 0);

        for (int r = 0; r < 3; r++) begin
            clear_cfg();
            for (int i = 0; i < N; i++) begin
                rdly[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                sdly[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                dirty[i] = ($urandom_range(0, 15) == 0);
                wdly[i]  = int'($urandom_range(0, 6));
            end
            run_fence("random", int'($urandom_range(0, 6)), 1, int'($urandom_range(0, 3)),
                      -1, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fence_i_sequencer.md
Name: fence_i_sequencer

Overview:
- Controller that runs a FENCE.I between the pipeline and the two caches.
- On a core request it stalls the core and waits for the D-cache to go idle.
- It then scans every D-cache line, sequences a write-back for each dirty line, triggers an I-cache flush, and finally returns a completion pulse to the core.
- It sits beside the d_cache / i_cache pair. It drives their maintenance ports only; it never touches the AXI side directly.

Parameters:
- SET_NUM, 64, sets per D-cache way (matches 6-bit SRAM index).
- WAY_NUM, 2, D-cache ways.
- LINE_W, 7, log2(SET_NUM*WAY_NUM). The line id is {way, set}, with way in the MSBs.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fence_req  in  1  level; core holds it high until fence_done is seen, then drops it.
- fence_done  out  1  one-cycle completion pulse.
- core_stall  out  1  freeze pipeline while a fence is in progress.
- dc_busy  in  1  D-cache is serving a core load/store or refill.
- scan_valid  out  1  request tag/dirty lookup of scan_line.
- scan_line  out  LINE_W  line being scanned.
- scan_ready  in  1  D-cache accepts the lookup.
- scan_rsp_valid  in  1  lookup result valid.
- scan_rsp_dirty  in  1  line is valid and dirty.
- wb_valid  out  1  request write-back of scan_line. D-cache clears dirty on completion.
- wb_done  in  1  write-back finished (AXI B received).
- icache_flush  out  1  one-cycle pulse to invalidate all I-cache lines.
- icache_flush_done  in  1  I-cache invalidation complete.
- wb_count  out  LINE_W+1  number of lines written back by the most recent fence.

Behaviour:
- Reset state:
  - All outputs are 0, line counter is 0, state is IDLE.
  - Reset mid-fence abandons the fence; no pulse is issued.
  - Any in-flight D-cache write-back is the D-cache's responsibility.
- State machine (registered, one transition per edge):
  - IDLE: fence_req=1 → DRAIN; clear line counter and wb_count.
  - DRAIN: dc_busy=0 → SCAN; otherwise stay.
  - SCAN: scan_valid=1, scan_line=counter; scan_ready=1 → WAIT_RSP.
  - WAIT_RSP: scan_rsp_valid=1 → WB if scan_rsp_dirty, else NEXT.
  - WB: wb_valid=1 with scan_line held; wb_done=1 → NEXT and wb_count+1.
  - NEXT: counter==SET_NUM*WAY_NUM-1 → IFLUSH; else counter+1 → SCAN.
  - IFLUSH: icache_flush=1 for exactly this cycle → IWAIT.
  - IWAIT: icache_flush_done=1 → DONE.
  - DONE: fence_done=1 on the first DONE cycle only; stay until fence_req=0, then → IDLE.
- Stall:
  - core_stall=1 in every state except IDLE; combinational from state.
  - core_stall drops in the cycle IDLE is re-entered.
- Handshakes:
  - scan_valid and wb_valid stay high until their ready/done signal. scan_line is stable throughout.
  - scan_rsp_valid, wb_done and icache_flush_done are ignored outside WAIT_RSP, WB and IWAIT respectively.
  - dc_busy is sampled only in DRAIN.
- Counters:
  - Line counter is LINE_W bits. Termination is by compare, never by wrap.
  - wb_count holds its value from DONE until the next fence starts, and saturates at SET_NUM*WAY_NUM.
- Re-trigger: fence_req still high in DONE does not restart a fence. A new fence needs fence_req low in DONE, then high again in IDLE.
- Latency: assume scan_ready always 1, scan_rsp_valid in the cycle after the handshake, dc_busy=0, and icache_flush_done in the first IWAIT cycle.
  - Clean lines cost 3 cycles each.
  - fence_done rises 3*N+4 edges after fence_req is sampled in IDLE, with N=SET_NUM*WAY_NUM.
  - Each dirty line adds 1 + (cycles until wb_done) cycles.

Test Plan:
- Clean cache (defaults, N=128) with ideal responders: fence_req high → fence_done pulses at edge 388; scan_line sweeps 0..127 in order; wb_valid never rises; wb_count=0; single icache_flush pulse.
- Dirty lines 5 and 70, wb_done after 10 cycles each: exactly two wb_valid windows with scan_line=5 then 70; wb_count=2; fence_done at edge 388+2*11.
- dc_busy high for 20 cycles at request: scan_valid stays low until dc_busy is low; core_stall high from the cycle after the request.
- scan_ready withheld 4 cycles on line 0, plus spurious wb_done and scan_rsp_valid while in SCAN: scan_valid and scan_line stay stable; the spurious inputs have no effect; the sequence completes normally.
- Reset asserted while in WB on line 33: the next cycle has all outputs 0 and state IDLE; a new fence restarts from line 0.
- fence_req held high 5 cycles past fence_done: no second fence; core_stall stays high until req drops, then falls; a re-request then runs a full fence.
